// File: rtl/if_prefetch_pkg.sv
// Shared constants and helpers for the if_prefetch fetch stage.
package if_prefetch_pkg;

  localparam int unsigned IfAddrW    = 32;
  localparam int unsigned IfInstW    = 32;
  localparam int unsigned IfDepth    = 4;
  localparam int unsigned InstBytes  = 4;
  localparam int unsigned PerfW      = 32;
  // Headroom on the drop counter so back-to-back redirects can stack stale responses.
  localparam int unsigned DropExtraW = 3;

  typedef logic [PerfW-1:0] perf_cnt_t;

  function automatic perf_cnt_t perf_sat_inc(input perf_cnt_t cnt, input logic inc);
    return (inc && (cnt != '1)) ? cnt + perf_cnt_t'(1) : cnt;
  endfunction

endpackage

// File: rtl/if_prefetch_slot_buf.sv
// Prefetch slot array: slots allocated at grant (pc), filled at response (inst), freed at pop.
module if_prefetch_slot_buf
  import if_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = IfAddrW,
  parameter int unsigned INST_W = IfInstW,
  parameter int unsigned DEPTH  = IfDepth,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_alloc,
  input  logic [ADDR_W-1:0] i_alloc_pc,
  input  logic              i_fill,
  input  logic [INST_W-1:0] i_fill_inst,
  input  logic              i_pop,
  output logic [PTR_W:0]    o_alloc_cnt,
  output logic [PTR_W:0]    o_pend_cnt,
  output logic              o_head_valid,
  output logic [ADDR_W-1:0] o_head_pc,
  output logic [INST_W-1:0] o_head_inst
);

  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [DEPTH-1:0]  r_filled;
  logic [DEPTH-1:0]  w_filled_d;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  r_fill;
  logic [PTR_W:0]    r_alloc_cnt;
  logic [PTR_W:0]    r_pend_cnt;

  // Head is always filled and the fill slot never is, so these indices cannot collide.
  always_comb begin
    w_filled_d = r_filled;
    if (i_fill) w_filled_d[r_fill] = 1'b1;
    if (i_pop)  w_filled_d[r_head] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filled    <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_fill      <= '0;
      r_alloc_cnt <= '0;
      r_pend_cnt  <= '0;
    end else if (i_flush) begin
      r_filled    <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_fill      <= '0;
      r_alloc_cnt <= '0;
      r_pend_cnt  <= '0;
    end else begin
      r_filled <= w_filled_d;
      if (i_alloc) r_tail <= r_tail + PTR_W'(1);
      if (i_fill)  r_fill <= r_fill + PTR_W'(1);
      if (i_pop)   r_head <= r_head + PTR_W'(1);
      r_alloc_cnt <= r_alloc_cnt + (PTR_W+1)'(i_alloc) - (PTR_W+1)'(i_pop);
      r_pend_cnt  <= r_pend_cnt + (PTR_W+1)'(i_alloc) - (PTR_W+1)'(i_fill);
    end
  end

  // Payload storage needs no reset; visibility is gated by the filled bits.
  always_ff @(posedge i_clk) begin
    if (i_alloc && !i_flush) r_pc[r_tail]   <= i_alloc_pc;
    if (i_fill && !i_flush)  r_inst[r_fill] <= i_fill_inst;
  end

  assign o_alloc_cnt  = r_alloc_cnt;
  assign o_pend_cnt   = r_pend_cnt;
  assign o_head_valid = r_filled[r_head];
  assign o_head_pc    = o_head_valid ? r_pc[r_head] : '0;
  assign o_head_inst  = o_head_valid ? r_inst[r_head] : '0;

endmodule

// File: rtl/if_prefetch.sv
// Fetch stage: PC generator, drop counter for flushed in-flight fetches, and prefetch buffer.
// Define IF_PERF_EN to build the saturating perf counters; otherwise o_perf_* are tied to zero.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IfAddrW,
  parameter int unsigned       INST_W   = IfInstW,
  parameter int unsigned       DEPTH    = IfDepth,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_id_valid,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [INST_W-1:0] o_id_inst,
  input  logic              i_id_ready,
  input  logic              i_redirect_en,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [PerfW-1:0]  o_perf_fetch,
  output logic [PerfW-1:0]  o_perf_flush,
  output logic [PerfW-1:0]  o_perf_stall
);

  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam int unsigned    DROP_W   = PTR_W + 1 + DropExtraW;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_d;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [DROP_W-1:0] w_drop_d;
  logic [PTR_W:0]    w_alloc_cnt;
  logic [PTR_W:0]    w_pend_cnt;
  logic              w_req;
  logic              w_grant;
  logic              w_drop;
  logic              w_fill;
  logic              w_pop;

  assign w_req   = (w_alloc_cnt < FULL_CNT) & ~i_redirect_en & ~i_rst;
  assign w_grant = w_req & i_imem_gnt;
  assign w_drop  = i_imem_rvalid & (r_drop_cnt != '0);
  // A response with nothing pending and nothing to drop is a protocol error and is ignored.
  assign w_fill  = i_imem_rvalid & (r_drop_cnt == '0) & (w_pend_cnt != '0);
  assign w_pop   = o_id_valid & i_id_ready;

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fetch_pc;

  always_comb begin
    w_fetch_pc_d = r_fetch_pc;
    if (i_redirect_en) begin
      w_fetch_pc_d = i_redirect_pc;
    end else if (w_grant) begin
      w_fetch_pc_d = r_fetch_pc + ADDR_W'(InstBytes);
    end
  end

  // On redirect every allocated-but-unfilled fetch becomes a drop, less the one landing now.
  always_comb begin
    w_drop_d = r_drop_cnt;
    if (w_drop) w_drop_d = w_drop_d - DROP_W'(1);
    if (i_redirect_en) w_drop_d = w_drop_d + DROP_W'(w_pend_cnt) - DROP_W'(w_fill);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_d;
      r_drop_cnt <= w_drop_d;
    end
  end

  if_prefetch_slot_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_slot_buf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_redirect_en),
    .i_alloc      (w_grant),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill       (w_fill),
    .i_fill_inst  (i_imem_rdata),
    .i_pop        (w_pop),
    .o_alloc_cnt  (w_alloc_cnt),
    .o_pend_cnt   (w_pend_cnt),
    .o_head_valid (o_id_valid),
    .o_head_pc    (o_id_pc),
    .o_head_inst  (o_id_inst)
  );

`ifdef IF_PERF_EN
  perf_cnt_t r_perf_fetch;
  perf_cnt_t r_perf_flush;
  perf_cnt_t r_perf_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_fetch <= perf_sat_inc(r_perf_fetch, w_pop);
      r_perf_flush <= perf_sat_inc(r_perf_flush, i_redirect_en);
      r_perf_stall <= perf_sat_inc(r_perf_stall, i_id_ready & ~o_id_valid);
    end
  end

  assign o_perf_fetch = r_perf_fetch;
  assign o_perf_flush = r_perf_flush;
  assign o_perf_stall = r_perf_stall;
`else
  assign o_perf_fetch = '0;
  assign o_perf_flush = '0;
  assign o_perf_stall = '0;
`endif

  a_rvalid_expected: assert property (@(posedge i_clk) disable iff (i_rst)
    i_imem_rvalid |-> ((r_drop_cnt != '0) || (w_pend_cnt != '0)));

  a_alloc_bounded: assert property (@(posedge i_clk) disable iff (i_rst)
    w_alloc_cnt <= FULL_CNT);

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: vector table plus hand-written redirect/reset sequences.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_id_valid;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_inst;
  logic        i_id_ready;
  logic        i_redirect_en;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_perf_fetch;
  logic [31:0] o_perf_flush;
  logic [31:0] o_perf_stall;

  always #5 clk = ~clk;

  if_prefetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_id_valid    (o_id_valid),
    .o_id_pc       (o_id_pc),
    .o_id_inst     (o_id_inst),
    .i_id_ready    (i_id_ready),
    .i_redirect_en (i_redirect_en),
    .i_redirect_pc (i_redirect_pc),
    .o_perf_fetch  (o_perf_fetch),
    .o_perf_flush  (o_perf_flush),
    .o_perf_stall  (o_perf_stall)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic [31:0] q_addr[$];
  int          q_due[$];

  typedef struct {
    bit          do_rst;
    bit          ready;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // In-order memory model: responds lat cycles after each grant.
  task automatic drive_mem();
    if (q_addr.size() != 0 && q_due[0] <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = inst_of(q_addr[0]);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
    end
  endtask

  task automatic tick();
    if (o_imem_req && i_imem_gnt) begin
      q_addr.push_back(o_imem_addr);
      q_due.push_back(cyc + lat);
    end
    if (i_imem_rvalid) begin
      q_addr.delete(0);
      q_due.delete(0);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset();
    i_rst         = 1'b1;
    i_id_ready    = 1'b0;
    i_redirect_en = 1'b0;
    i_redirect_pc = '0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    q_addr.delete();
    q_due.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    cyc   = 0;
    drive_mem();
  endtask

  task automatic step(input string tag, input logic ready, input logic redir,
                      input logic [31:0] rpc, input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_valid, input logic [31:0] exp_pc);
    i_id_ready    = ready;
    i_redirect_en = redir;
    i_redirect_pc = rpc;
    #1;
    check({tag, ".req"},   64'(o_imem_req), 64'(exp_req));
    check({tag, ".addr"},  64'(o_imem_addr), 64'(exp_addr));
    check({tag, ".valid"}, 64'(o_id_valid), 64'(exp_valid));
    check({tag, ".pc"},    64'(o_id_pc), 64'(exp_pc));
    check({tag, ".inst"},  64'(o_id_inst), 64'(exp_valid ? inst_of(exp_pc) : 32'h0));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_flush;

    // Streaming: ready=1, 1-cycle memory; then back-pressure until full with DEPTH=4.
    vecs[0]  = '{1, 1, 1, 32'd0,  0, 32'd0};
    vecs[1]  = '{0, 1, 1, 32'd4,  0, 32'd0};
    vecs[2]  = '{0, 1, 1, 32'd8,  1, 32'd0};
    vecs[3]  = '{0, 1, 1, 32'd12, 1, 32'd4};
    vecs[4]  = '{0, 1, 1, 32'd16, 1, 32'd8};
    vecs[5]  = '{0, 1, 1, 32'd20, 1, 32'd12};
    vecs[6]  = '{1, 0, 1, 32'd0,  0, 32'd0};
    vecs[7]  = '{0, 0, 1, 32'd4,  0, 32'd0};
    vecs[8]  = '{0, 0, 1, 32'd8,  1, 32'd0};
    vecs[9]  = '{0, 0, 1, 32'd12, 1, 32'd0};
    vecs[10] = '{0, 0, 0, 32'd16, 1, 32'd0};
    vecs[11] = '{0, 1, 0, 32'd16, 1, 32'd0};
    vecs[12] = '{0, 0, 1, 32'd16, 1, 32'd4};
    vecs[13] = '{0, 0, 0, 32'd20, 1, 32'd4};

    i_imem_gnt = 1'b1;
    do_reset();
    check("reset.req",   64'(o_imem_req), 64'(0));
    check("reset.valid", 64'(o_id_valid), 64'(0));

    lat = 1;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_rst) do_reset();
      step($sformatf("vec%0d", i), vecs[i].ready, 1'b0, 32'h0, vecs[i].exp_req,
           vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // Redirect with three fetches in flight on a slow memory: all three must be dropped.
    do_reset();
    lat = 4;
    step("t3c0", 1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    step("t3c1", 1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
    step("t3c2", 1, 0, 32'h0,   1, 32'h8,   0, 32'h0);
    step("t3c3", 1, 1, 32'h100, 0, 32'hC,   0, 32'h0);
    step("t3c4", 1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    step("t3c5", 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    step("t3c6", 1, 0, 32'h0,   1, 32'h108, 0, 32'h0);
    step("t3c7", 1, 0, 32'h0,   1, 32'h10C, 0, 32'h0);
    step("t3c8", 1, 0, 32'h0,   0, 32'h110, 0, 32'h0);
    step("t3c9", 1, 0, 32'h0,   0, 32'h110, 1, 32'h100);

    // Redirect coinciding with pop of pc 8 and the response for pc 12.
    do_reset();
    lat = 2;
    step("t4c0",  1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    step("t4c1",  1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
    step("t4c2",  1, 0, 32'h0,   1, 32'h8,   0, 32'h0);
    step("t4c3",  1, 0, 32'h0,   1, 32'hC,   1, 32'h0);
    step("t4c4",  1, 0, 32'h0,   1, 32'h10,  1, 32'h4);
    step("t4c5",  1, 1, 32'h200, 0, 32'h14,  1, 32'h8);
    step("t4c6",  1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
    step("t4c7",  1, 0, 32'h0,   1, 32'h204, 0, 32'h0);
    step("t4c8",  1, 0, 32'h0,   1, 32'h208, 0, 32'h0);
    step("t4c9",  1, 0, 32'h0,   1, 32'h20C, 1, 32'h200);
    step("t4c10", 1, 0, 32'h0,   1, 32'h210, 1, 32'h204);

    // Address wrap at the top of the address space.
    do_reset();
    lat = 1;
    step("t5c0", 1, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0);
    step("t5c1", 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
    step("t5c2", 1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
    step("t5c3", 1, 0, 32'h0,         1, 32'h4,         1, 32'hFFFF_FFFC);
    step("t5c4", 1, 0, 32'h0,         1, 32'h8,         1, 32'h0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    lat = 1;
    step("t6c0", 1, 0, 32'h0, 1, 32'h0,  0, 32'h0);
    step("t6c1", 1, 0, 32'h0, 1, 32'h4,  0, 32'h0);
    step("t6c2", 1, 0, 32'h0, 1, 32'h8,  1, 32'h0);
    step("t6c3", 1, 0, 32'h0, 1, 32'hC,  1, 32'h4);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst.req",   64'(o_imem_req), 64'(0));
    check("arst.addr",  64'(o_imem_addr), 64'(0));
    check("arst.valid", 64'(o_id_valid), 64'(0));
    check("arst.pc",    64'(o_id_pc), 64'(0));
    check("arst.inst",  64'(o_id_inst), 64'(0));
    check("arst.pfetch", 64'(o_perf_fetch), 64'(0));
    check("arst.pflush", 64'(o_perf_flush), 64'(0));
    check("arst.pstall", 64'(o_perf_stall), 64'(0));
    do_reset();
    step("t6r0", 1, 0, 32'h0, 1, 32'h0, 0, 32'h0);
    step("t6r1", 1, 0, 32'h0, 1, 32'h4, 0, 32'h0);
    step("t6r2", 1, 0, 32'h0, 1, 32'h8, 1, 32'h0);
    step("t6r3", 1, 1, 32'h40, 0, 32'hC, 1, 32'h4);
    #1;
`ifdef IF_PERF_EN
    exp_flush = 32'd1;
`else
    exp_flush = 32'd0;
`endif
    check("perf.flush", 64'(o_perf_flush), 64'(exp_flush));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
